sift_top_epp: RTL and testbench
===============================

# sift_top_epp

Host-link front end of the SIFT accelerator (`sift_top`): a Digilent-style EPP slave that lets a PC write a grayscale frame byte by byte, and read back status and integrity registers. It counts pixels, computes a running checksum, raises an interrupt when a full frame has arrived, and shows load state on two LEDs. Downstream SIFT stages attach to the frame-done status.

## Interface
- IMG_PIXELS, 262144: frame size in bytes (512×512); range 1..2^24−1.
- clk_sys  in  1  system clock; all logic on its rising edge.
- rst_sys  in  1  asynchronous, active-high reset.
- EPP_Write0  in  1  host direction: 0 = host write, 1 = host read.
- EPP_DataStrobe0  in  1  data strobe, active low.
- EPP_AddressStrobe0  in  1  address strobe, active low.
- EPP_Reset0  in  1  host reset, active low; synchronous soft clear.
- EPP_Data  inout  8  bidirectional bus; driven only during read cycles.
- EPP_Interrupt  out  1  frame-complete interrupt, level, active high.
- EPP_Wait  out  1  handshake acknowledge, active high.
- led1  out  1  frame_done.
- led2  out  1  loading: count > 0 and not frame_done.

## Operation
- All four EPP inputs pass through 2-flop synchronizers into clk_sys.
- FSM states: IDLE, ADDR_WR, ADDR_RD, DATA_WR, DATA_RD, RELEASE.
- From IDLE, on a synchronized strobe low:
  - Address strobe with write → ADDR_WR: latch EPP_Data into the 8-bit address register.
  - Address strobe with read → ADDR_RD: drive the address register onto the bus.
  - Data strobe with write → DATA_WR: perform a register write at the current address.
  - Data strobe with read → DATA_RD: drive the register read value onto the bus.
- Each action state lasts one cycle and asserts EPP_Wait, then goes to RELEASE. RELEASE holds EPP_Wait and any bus drive until both strobes are high, then returns to IDLE.
- Both strobes low at the same time in IDLE: ignored, no EPP_Wait.
- Register map (address register value; unmapped addresses read 0x00, writes ignored):
  - 0x00 CTRL, W: bit0 start (clears count, checksum, frame_done, overflow); bit1 irq_ack (clears irq_pending).
  - 0x01 STATUS, R: {4'b0, overflow, irq_pending, frame_done, loading}.
  - 0x02 PIXEL, W: pixel byte; R: last accepted pixel.
  - 0x03–0x05 COUNT[7:0], [15:8], [23:16], R.
  - 0x06–0x09 CSUM[7:0] … [31:24], R.
  - 0x0A ID, R: constant 0x51.
- PIXEL write with frame_done=0: count += 1; checksum += pixel (mod 2^32); last pixel updated. When the new count equals IMG_PIXELS, set frame_done and irq_pending in the same cycle.
- PIXEL write with frame_done=1: byte discarded, overflow set, count unchanged.
- Start and a frame-completing write never coincide, because they are separate EPP cycles.
- EPP_Interrupt = irq_pending. led1 = frame_done. led2 = loading.
- Synchronized EPP_Reset0 low: clears the address register, count, checksum, flags and last pixel; forces the FSM to IDLE and releases EPP_Wait. This has the same effect as rst_sys.

## Timing
- Reset values: EPP_Wait 0, EPP_Interrupt 0, led1 0, led2 0, EPP_Data high-Z, all registers 0, FSM IDLE.
- EPP_Wait rises exactly 3 clk_sys edges after a strobe falls: 2 synchronizer edges plus 1 action edge.
- Write data and address are captured from the synchronized bus on the action edge. The host holds data stable while the strobe is low.
- Read data is valid on EPP_Data no later than the EPP_Wait rise, and is held until the strobe rises.
- EPP_Wait falls 3 edges after the strobe rises. The bus returns to high-Z on that same edge.
- Counters, flags and LEDs update on the action edge. EPP_Interrupt rises on the edge of the completing write.
- rst_sys asserted mid-handshake: immediate asynchronous return to reset values. The host then sees EPP_Wait drop.

## Configuration
- SIFT_CHECKSUM_EN:
  - Defined: the CSUM accumulator exists and 0x06–0x09 return its bytes.
  - Undefined: no accumulator is synthesized; 0x06–0x09 read 0x00.
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then an address write of 0x0A followed by a data read → EPP_Data=0x51; EPP_Wait rises 3 cycles after the strobe falls; LEDs and EPP_Interrupt are 0.
- Address write 0x37, then address read → 0x37; EPP_Data is high-Z outside the read cycle.
- IMG_PIXELS=4: CTRL=0x01, then PIXEL writes 10, 20, 30, 40:
  - STATUS=0x06, COUNT=4, CSUM=100 (0 without the macro);
  - led1=1, led2=0, EPP_Interrupt=1 on the 4th write.
- A 5th PIXEL write of 0xFF → overflow=1 (STATUS=0x0E); COUNT stays 4; PIXEL reads 40.
- CTRL=0x02 → EPP_Interrupt=0. Then CTRL=0x01 → STATUS=0x00; COUNT and CSUM are 0.
- After 2 pixel writes, pulse EPP_Reset0 low → all registers 0, led2 drops. Separately, assert rst_sys while EPP_Wait=1 → EPP_Wait goes to 0 asynchronously.

Source files
------------

// File: rtl/sift_top_epp.sv
// sift_top_epp: EPP slave host link that loads a frame byte by byte, counts pixels and flags frame completion.
// Optional build macro SIFT_CHECKSUM_EN adds the 32-bit CSUM accumulator read at 0x06-0x09.
module sift_top_epp #(
    parameter int IMG_PIXELS = 262144
) (
    input  logic       clk_sys,
    input  logic       rst_sys,
    input  logic       EPP_Write0,
    input  logic       EPP_DataStrobe0,
    input  logic       EPP_AddressStrobe0,
    input  logic       EPP_Reset0,
    inout  wire  [7:0] EPP_Data,
    output logic       EPP_Interrupt,
    output logic       EPP_Wait,
    output logic       led1,
    output logic       led2
);
    typedef enum logic [2:0] {IDLE, ADDR_WR, ADDR_RD, DATA_WR, DATA_RD, RELEASE} state_t;
    localparam logic [23:0] FRAME = 24'(IMG_PIXELS);
    logic [1:0]  wr_q, ds_q, as_q, rs_q;
    logic [7:0]  d1_q, d2_q;
    state_t      state_q;
    logic        wait_q, drive_q, done_q, irq_q, ovf_q;
    logic [7:0]  rdata_q, addr_q, last_q, rd_d;
    logic [23:0] count_q, count_d;
    logic        loading;
`ifdef SIFT_CHECKSUM_EN
    logic [31:0] csum_q;
`endif
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            wr_q <= 2'b11;
            ds_q <= 2'b11;
            as_q <= 2'b11;
            rs_q <= 2'b11;
            d1_q <= 8'h00;
            d2_q <= 8'h00;
        end else begin
            wr_q <= {wr_q[0], EPP_Write0};
            ds_q <= {ds_q[0], EPP_DataStrobe0};
            as_q <= {as_q[0], EPP_AddressStrobe0};
            rs_q <= {rs_q[0], EPP_Reset0};
            d1_q <= EPP_Data;
            d2_q <= d1_q;
        end
    end
    assign loading = (count_q != '0) && !done_q;
    assign count_d = count_q + 24'd1;
    always_comb begin
        rd_d = 8'h00;
        case (addr_q)
            8'h01: rd_d = {4'b0000, ovf_q, irq_q, done_q, loading};
            8'h02: rd_d = last_q;
            8'h03: rd_d = count_q[7:0];
            8'h04: rd_d = count_q[15:8];
            8'h05: rd_d = count_q[23:16];
`ifdef SIFT_CHECKSUM_EN
            8'h06: rd_d = csum_q[7:0];
            8'h07: rd_d = csum_q[15:8];
            8'h08: rd_d = csum_q[23:16];
            8'h09: rd_d = csum_q[31:24];
`endif
            8'h0A: rd_d = 8'h51;
            default: rd_d = 8'h00;
        endcase
    end
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_q <= IDLE;
            wait_q  <= 1'b0;
            drive_q <= 1'b0;
            rdata_q <= 8'h00;
            addr_q  <= 8'h00;
            count_q <= '0;
            last_q  <= 8'h00;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SIFT_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else if (!rs_q[1]) begin
            state_q <= IDLE;
            wait_q  <= 1'b0;
            drive_q <= 1'b0;
            rdata_q <= 8'h00;
            addr_q  <= 8'h00;
            count_q <= '0;
            last_q  <= 8'h00;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SIFT_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // exactly one strobe low starts a cycle; the action happens on this edge
                    if (!as_q[1] && ds_q[1]) begin
                        state_q <= wr_q[1] ? ADDR_RD : ADDR_WR;
                        wait_q  <= 1'b1;
                        if (wr_q[1]) begin
                            rdata_q <= addr_q;
                            drive_q <= 1'b1;
                        end else begin
                            addr_q <= d2_q;
                        end
                    end else if (!ds_q[1] && as_q[1]) begin
                        state_q <= wr_q[1] ? DATA_RD : DATA_WR;
                        wait_q  <= 1'b1;
                        if (wr_q[1]) begin
                            rdata_q <= rd_d;
                            drive_q <= 1'b1;
                        end else if (addr_q == 8'h00) begin
                            if (d2_q[0]) begin
                                count_q <= '0;
                                done_q  <= 1'b0;
                                ovf_q   <= 1'b0;
`ifdef SIFT_CHECKSUM_EN
                                csum_q  <= '0;
`endif
                            end
                            if (d2_q[1])
                                irq_q <= 1'b0;
                        end else if (addr_q == 8'h02) begin
                            if (done_q) begin
                                ovf_q <= 1'b1;
                            end else begin
                                count_q <= count_d;
                                last_q  <= d2_q;
`ifdef SIFT_CHECKSUM_EN
                                csum_q  <= csum_q + {24'd0, d2_q};
`endif
                                if (count_d == FRAME) begin
                                    done_q <= 1'b1;
                                    irq_q  <= 1'b1;
                                end
                            end
                        end
                    end
                end
                ADDR_WR, ADDR_RD, DATA_WR, DATA_RD: state_q <= RELEASE;
                RELEASE: begin
                    if (as_q[1] && ds_q[1]) begin
                        state_q <= IDLE;
                        wait_q  <= 1'b0;
                        drive_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign EPP_Data      = drive_q ? rdata_q : 8'hzz;
    assign EPP_Wait      = wait_q;
    assign EPP_Interrupt = irq_q;
    assign led1          = done_q;
    assign led2          = loading;
endmodule

// File: tb/tb_sift_top_epp.sv
// tb_sift_top_epp: vector table plus randomized host traffic checked against a frame-level model.
module tb_sift_top_epp;
    localparam int NPIX = 4;
`ifdef SIFT_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif
    localparam logic [7:0] CSUM_LO = CSUM_ON ? 8'd100 : 8'd0;

    logic clk = 1'b0, rst = 1'b1;
    logic write_n = 1'b1, ds_n = 1'b1, as_n = 1'b1, rst0_n = 1'b1;
    logic host_en = 1'b0;
    logic [7:0] host_val = 8'h00;
    wire  [7:0] bus;
    logic irq, wt, l1, l2;
    int n_cmp = 0, n_bad = 0;

    assign bus = host_en ? host_val : 8'hzz;

    sift_top_epp #(.IMG_PIXELS(NPIX)) dut (
        .clk_sys(clk), .rst_sys(rst), .EPP_Write0(write_n), .EPP_DataStrobe0(ds_n),
        .EPP_AddressStrobe0(as_n), .EPP_Reset0(rst0_n), .EPP_Data(bus),
        .EPP_Interrupt(irq), .EPP_Wait(wt), .led1(l1), .led2(l2)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string nm, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // frame-level reference model
    int m_cnt, m_addr;
    bit [31:0] m_sum;
    logic [7:0] m_last;
    bit m_done, m_irq, m_ovf;

    task automatic m_reset();
        m_cnt = 0; m_addr = 0; m_sum = 0; m_last = 0; m_done = 0; m_irq = 0; m_ovf = 0;
    endtask

    task automatic m_write(input logic [7:0] v);
        if (m_addr == 0) begin
            if (v[0]) begin m_cnt = 0; m_sum = 0; m_done = 0; m_ovf = 0; end
            if (v[1]) m_irq = 0;
        end else if (m_addr == 2) begin
            if (m_done) m_ovf = 1;
            else begin
                m_cnt++;
                m_sum += 32'(v);
                m_last = v;
                if (m_cnt == NPIX) begin m_done = 1; m_irq = 1; end
            end
        end
    endtask

    function automatic logic [7:0] m_read(input int a);
        if (a == 1) return {4'b0, m_ovf, m_irq, m_done, (m_cnt > 0) && !m_done};
        if (a == 2) return m_last;
        if (a >= 3 && a <= 5) return 8'(m_cnt >> (8 * (a - 3)));
        if (a >= 6 && a <= 9) return CSUM_ON ? 8'(m_sum >> (8 * (a - 6))) : 8'h00;
        if (a == 10) return 8'h51;
        return 8'h00;
    endfunction

    // one full EPP handshake; checks Wait latency in both directions
    task automatic epp(input bit a, input bit r, input logic [7:0] v, output logic [7:0] rv);
        int n;
        @(negedge clk);
        write_n = r; host_en = !r; host_val = v;
        if (a) as_n = 1'b0; else ds_n = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!wt && n < 20);
        check("wait_rise_edges", n, 3);
        rv = bus;
        @(negedge clk);
        as_n = 1'b1; ds_n = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (wt && n < 20);
        check("wait_fall_edges", n, 3);
        host_en = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_free(input string nm);
        host_en = 1'b1; host_val = 8'h5A;
        #1 check(nm, bus, 8'h5A);
        host_en = 1'b0;
    endtask

    typedef struct {
        bit a; bit r; logic [7:0] v; logic [7:0] e; bit e1; bit e2; bit ei;
    } vec_t;
    vec_t tbl[$];
    logic [7:0] rv;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_wait", wt, 0);
        check("reset_irq", irq, 0);
        check("reset_led1", l1, 0);
        check("reset_led2", l2, 0);
        bus_free("reset_bus_hiz");
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        tbl.push_back('{1, 0, 8'h0A, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h00, 8'h51, 0, 0, 0});
        tbl.push_back('{1, 0, 8'h37, 8'h00, 0, 0, 0});
        tbl.push_back('{1, 1, 8'h00, 8'h37, 0, 0, 0});
        tbl.push_back('{1, 0, 8'h00, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 0, 8'h01, 8'h00, 0, 0, 0});
        tbl.push_back('{1, 0, 8'h02, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 0, 8'd10, 8'h00, 0, 1, 0});
        tbl.push_back('{0, 0, 8'd20, 8'h00, 0, 1, 0});
        tbl.push_back('{0, 0, 8'd30, 8'h00, 0, 1, 0});
        tbl.push_back('{0, 0, 8'd40, 8'h00, 1, 0, 1});
        tbl.push_back('{1, 0, 8'h01, 8'h00, 1, 0, 1});
        tbl.push_back('{0, 1, 8'h00, 8'h06, 1, 0, 1});
        tbl.push_back('{1, 0, 8'h03, 8'h00, 1, 0, 1});
        tbl.push_back('{0, 1, 8'h00, 8'h04, 1, 0, 1});
        tbl.push_back('{1, 0, 8'h04, 8'h00, 1, 0, 1});
        tbl.push_back('{0, 1, 8'h00, 8'h00, 1, 0, 1});
        tbl.push_back('{1, 0, 8'h06, 8'h00, 1, 0, 1});
        tbl.push_back('{0, 1, 8'h00, CSUM_LO, 1, 0, 1});
        tbl.push_back('{1, 0, 8'h02, 8'h00, 1, 0, 1});
        tbl.push_back('{0, 0, 8'hFF, 8'h00, 1, 0, 1});
        tbl.push_back('{0, 1, 8'h00, 8'd40, 1, 0, 1});
        tbl.push_back('{1, 0, 8'h01, 8'h00, 1, 0, 1});
        tbl.push_back('{0, 1, 8'h00, 8'h0E, 1, 0, 1});
        tbl.push_back('{1, 0, 8'h03, 8'h00, 1, 0, 1});
        tbl.push_back('{0, 1, 8'h00, 8'h04, 1, 0, 1});
        tbl.push_back('{1, 0, 8'h00, 8'h00, 1, 0, 1});
        tbl.push_back('{0, 0, 8'h02, 8'h00, 1, 0, 0});
        tbl.push_back('{0, 0, 8'h01, 8'h00, 0, 0, 0});
        tbl.push_back('{1, 0, 8'h01, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h00, 8'h00, 0, 0, 0});
        tbl.push_back('{1, 0, 8'h03, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h00, 8'h00, 0, 0, 0});
        tbl.push_back('{1, 0, 8'h06, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h00, 8'h00, 0, 0, 0});
        tbl.push_back('{1, 0, 8'h0B, 8'h00, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h00, 8'h00, 0, 0, 0});

        foreach (tbl[i]) begin
            epp(tbl[i].a, tbl[i].r, tbl[i].v, rv);
            if (tbl[i].r) check($sformatf("vec%0d_read", i), rv, tbl[i].e);
            check($sformatf("vec%0d_led1", i), l1, tbl[i].e1);
            check($sformatf("vec%0d_led2", i), l2, tbl[i].e2);
            check($sformatf("vec%0d_irq", i), irq, tbl[i].ei);
            if (i == 3) bus_free("bus_hiz_after_read");
        end

        // both strobes low together must be ignored
        @(negedge clk);
        as_n = 1'b0; ds_n = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("both_strobes_no_wait", wt, 0);
        @(negedge clk);
        as_n = 1'b1; ds_n = 1'b1;
        repeat (4) @(negedge clk);

        // EPP_Reset0 soft clear mid-frame
        epp(1, 0, 8'h00, rv);
        epp(0, 0, 8'h01, rv);
        epp(1, 0, 8'h02, rv);
        epp(0, 0, 8'h11, rv);
        epp(0, 0, 8'h22, rv);
        check("soft_pre_led2", l2, 1);
        @(negedge clk) rst0_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("soft_led2", l2, 0);
        @(negedge clk) rst0_n = 1'b1;
        repeat (4) @(negedge clk);
        epp(1, 1, 8'h00, rv);
        check("soft_addr", rv, 8'h00);
        epp(1, 0, 8'h02, rv);
        epp(0, 1, 8'h00, rv);
        check("soft_pixel", rv, 8'h00);
        epp(1, 0, 8'h03, rv);
        epp(0, 1, 8'h00, rv);
        check("soft_count", rv, 8'h00);
        epp(1, 0, 8'h06, rv);
        epp(0, 1, 8'h00, rv);
        check("soft_csum", rv, 8'h00);

        // randomized traffic against the model
        m_reset();
        for (int k = 0; k < 300; k++) begin
            int op, r;
            logic [7:0] v;
            if (k == 0 || $urandom_range(0, 9) < 4) begin
                r = $urandom_range(0, 5);
                m_addr = r < 3 ? 2 : r < 4 ? 0 : $urandom_range(0, 15);
                epp(1, 0, 8'(m_addr), rv);
            end
            op = $urandom_range(0, 9);
            if (op == 0) begin
                epp(1, 1, 8'h00, rv);
                check("rnd_addr_read", rv, m_addr);
            end else if (op < 3) begin
                epp(0, 1, 8'h00, rv);
                check($sformatf("rnd_read_a%0h", m_addr), rv, m_read(m_addr));
            end else begin
                v = m_addr == 0 ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
                epp(0, 0, v, rv);
                m_write(v);
            end
            check("rnd_led1", l1, m_done);
            check("rnd_led2", l2, (m_cnt > 0) && !m_done);
            check("rnd_irq", irq, m_irq);
        end

        // rst_sys during a held handshake drops Wait without a clock edge
        epp(1, 0, 8'h0A, rv);
        @(negedge clk);
        write_n = 1'b1; ds_n = 1'b0;
        for (int n = 0; n < 20 && !wt; n++) begin @(posedge clk); #1; end
        check("async_pre_wait", wt, 1);
        #2 rst = 1'b1;
        #1 check("async_wait_drop", wt, 0);
        bus_free("async_bus_hiz");
        @(negedge clk);
        ds_n = 1'b1;
        @(negedge clk) rst = 1'b0;
        repeat (4) @(negedge clk);
        epp(1, 0, 8'h03, rv);
        epp(0, 1, 8'h00, rv);
        check("async_count_clear", rv, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
